register_lsu_multi_controller: RTL and testbench

Parametrised issue controller that feeds N_UNITS identical register load/store units from one shared in-order issue queue.
- Each queue entry captures the instruction together with its CSR matrix configuration at dispatch time, so later CSR writes cannot corrupt pending entries.
- Heads are issued to idle units in round-robin order.
- Sits between the matrix dispatcher and the LSU array.

---
 rtl/register_lsu_multi_controller.sv | 162 ++++++++++++++++
 tb/tb_register_lsu_multi_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/register_lsu_multi_controller.sv
// Shared in-order issue queue feeding N_UNITS register load/store units in round-robin order.
// Optional issue/stall statistics counters are enabled by defining LSU_ISSUE_STATS_EN.
module register_lsu_multi_controller #(
    parameter int unsigned N_SLOTS = 4,
    parameter int unsigned N_UNITS = 2,
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned CONF_W  = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            flush_i,
    input  logic                            dispatch_i,
    output logic                            dispatch_ready_o,
    input  logic [INSTR_W-1:0]              dispatched_instr_i,
    input  logic [CONF_W-1:0]               csr_config_i,
    input  logic [N_UNITS-1:0]              busy_i,
    output logic [N_UNITS-1:0]              start_o,
    output logic [N_UNITS*INSTR_W-1:0]      issued_instr_o,
    output logic [N_UNITS*CONF_W-1:0]       issued_conf_o,
`ifdef LSU_ISSUE_STATS_EN
    output logic [31:0]                     issue_cnt_o,
    output logic [31:0]                     stall_cnt_o,
`endif
    output logic [$clog2(N_SLOTS+1)-1:0]    usage_o
);

    localparam int unsigned PTR_W = $clog2(N_SLOTS);
    localparam int unsigned CNT_W = $clog2(N_SLOTS + 1);
    localparam int unsigned RR_W  = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [CONF_W-1:0]  conf;
    } entry_t;

    entry_t                     r_queue [N_SLOTS];
    logic [PTR_W-1:0]           r_rd_ptr;
    logic [PTR_W-1:0]           r_wr_ptr;
    logic [CNT_W-1:0]           r_count;
    logic [RR_W-1:0]            r_rr_ptr;
    logic [N_UNITS-1:0]         r_start;
    logic [N_UNITS*INSTR_W-1:0] r_issued_instr;
    logic [N_UNITS*CONF_W-1:0]  r_issued_conf;

    logic [N_UNITS-1:0]         w_idle;
    logic [RR_W-1:0]            w_sel;
    logic [RR_W-1:0]            w_rr_next;
    logic                       w_push;
    logic                       w_issue;
    logic                       w_stall;
    entry_t                     w_head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N_SLOTS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign dispatch_ready_o = (r_count != CNT_W'(N_SLOTS));
    assign usage_o          = r_count;
    assign start_o          = r_start;
    assign issued_instr_o   = r_issued_instr;
    assign issued_conf_o    = r_issued_conf;

    // A unit that was just started has not raised busy yet, so treat it as taken.
    assign w_idle  = ~busy_i & ~r_start;
    assign w_head  = r_queue[r_rd_ptr];
    assign w_push  = dispatch_i && dispatch_ready_o && !flush_i;
    assign w_issue = (r_count != '0) && !flush_i && (|w_idle);
    assign w_stall = (r_count != '0) && !flush_i && !(|w_idle);
    assign w_rr_next = (w_sel == RR_W'(N_UNITS - 1)) ? '0 : w_sel + RR_W'(1);

    // First idle unit at or after the round-robin pointer, searched cyclically.
    always_comb begin
        int unsigned idx;
        logic        found;
        w_sel = '0;
        idx   = 0;
        found = 1'b0;
        for (int unsigned k = 0; k < N_UNITS; k++) begin
            idx = 32'(r_rr_ptr) + k;
            if (idx >= N_UNITS) begin
                idx = idx - N_UNITS;
            end
            if (!found && w_idle[idx]) begin
                w_sel = RR_W'(idx);
                found = 1'b1;
            end
        end
    end

    // Entry payload storage; no reset needed since count gates every read.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_queue[r_wr_ptr] <= '{instr: dispatched_instr_i, conf: csr_config_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_issue) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_issue})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Issue registers: start is a single-cycle pulse, issued slices hold until re-issued.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_start        <= '0;
            r_issued_instr <= '0;
            r_issued_conf  <= '0;
            r_rr_ptr       <= '0;
        end else begin
            r_start <= '0;
            if (w_issue) begin
                r_start[w_sel]                             <= 1'b1;
                r_issued_instr[w_sel*INSTR_W +: INSTR_W]   <= w_head.instr;
                r_issued_conf[w_sel*CONF_W +: CONF_W]      <= w_head.conf;
                r_rr_ptr                                   <= w_rr_next;
            end
        end
    end

`ifdef LSU_ISSUE_STATS_EN
    logic [31:0] r_issue_cnt;
    logic [31:0] r_stall_cnt;

    assign issue_cnt_o = r_issue_cnt;
    assign stall_cnt_o = r_stall_cnt;

    // Issue count wraps; stall count saturates. Neither is cleared by flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_issue_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_issue) begin
                r_issue_cnt <= r_issue_cnt + 32'd1;
            end
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_register_lsu_multi_controller.sv
// Directed self-checking bench for register_lsu_multi_controller (N_SLOTS=4, N_UNITS=2).
module tb_register_lsu_multi_controller;

    localparam int unsigned N_SLOTS = 4;
    localparam int unsigned N_UNITS = 2;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CONF_W  = 32;

    logic                         clk_i = 1'b0;
    logic                         rst_ni = 1'b0;
    logic                         flush_i = 1'b0;
    logic                         dispatch_i = 1'b0;
    logic                         dispatch_ready_o;
    logic [INSTR_W-1:0]           dispatched_instr_i = '0;
    logic [CONF_W-1:0]            csr_config_i = '0;
    logic [N_UNITS-1:0]           busy_i = '0;
    logic [N_UNITS-1:0]           start_o;
    logic [N_UNITS*INSTR_W-1:0]   issued_instr_o;
    logic [N_UNITS*CONF_W-1:0]    issued_conf_o;
    logic [2:0]                   usage_o;
`ifdef LSU_ISSUE_STATS_EN
    logic [31:0]                  issue_cnt_o;
    logic [31:0]                  stall_cnt_o;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    register_lsu_multi_controller #(
        .N_SLOTS(N_SLOTS), .N_UNITS(N_UNITS), .INSTR_W(INSTR_W), .CONF_W(CONF_W)
    ) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .flush_i            (flush_i),
        .dispatch_i         (dispatch_i),
        .dispatch_ready_o   (dispatch_ready_o),
        .dispatched_instr_i (dispatched_instr_i),
        .csr_config_i       (csr_config_i),
        .busy_i             (busy_i),
        .start_o            (start_o),
        .issued_instr_o     (issued_instr_o),
        .issued_conf_o      (issued_conf_o),
`ifdef LSU_ISSUE_STATS_EN
        .issue_cnt_o        (issue_cnt_o),
        .stall_cnt_o        (stall_cnt_o),
`endif
        .usage_o            (usage_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] ins(input int u);
        return issued_instr_o[u*INSTR_W +: INSTR_W];
    endfunction

    function automatic logic [31:0] cnf(input int u);
        return issued_conf_o[u*CONF_W +: CONF_W];
    endfunction

    // Advance to just after the next rising edge; inputs are driven and outputs sampled here.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0; flush_i = 1'b0; dispatch_i = 1'b0; busy_i = '0;
        dispatched_instr_i = '0; csr_config_i = '0;
        step(); step();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #2;
        n_cmp++; if (start_o !== 2'b00) begin n_fail++; $display("FAIL reset_start: got %b want 00", start_o); end
        n_cmp++; if (usage_o !== 3'd0) begin n_fail++; $display("FAIL reset_usage: got %0d want 0", usage_o); end
        n_cmp++; if (dispatch_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", dispatch_ready_o); end
        n_cmp++; if (issued_instr_o !== 64'd0 || issued_conf_o !== 64'd0) begin
            n_fail++; $display("FAIL reset_slices: got %h/%h want 0/0", issued_instr_o, issued_conf_o); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        dispatch_i = 1'b1; dispatched_instr_i = 32'hA; csr_config_i = 32'h5;
        step();
        dispatch_i = 1'b0;
        n_cmp++; if (usage_o !== 3'd1) begin n_fail++; $display("FAIL single_usage_c1: got %0d want 1", usage_o); end
        n_cmp++; if (start_o !== 2'b00) begin n_fail++; $display("FAIL single_no_fallthrough: got %b want 00", start_o); end
        step();
        n_cmp++; if (start_o !== 2'b01) begin n_fail++; $display("FAIL single_start_c2: got %b want 01", start_o); end
        n_cmp++; if (ins(0) !== 32'hA || cnf(0) !== 32'h5) begin
            n_fail++; $display("FAIL single_slice0: got %h/%h want a/5", ins(0), cnf(0)); end
        n_cmp++; if (usage_o !== 3'd0) begin n_fail++; $display("FAIL single_usage_c2: got %0d want 0", usage_o); end
        step();
        n_cmp++; if (start_o !== 2'b00) begin n_fail++; $display("FAIL single_pulse_width: got %b want 00", start_o); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        dispatch_i = 1'b1; dispatched_instr_i = 32'hA;             // c0
        step(); dispatched_instr_i = 32'hB;                         // c1
        step(); dispatched_instr_i = 32'hC;                         // c2
        n_cmp++; if (start_o !== 2'b01 || ins(0) !== 32'hA) begin
            n_fail++; $display("FAIL b2b_A_unit0: got start %b instr %h want 01/a", start_o, ins(0)); end
        step(); dispatch_i = 1'b0; busy_i = 2'b01;                  // c3
        n_cmp++; if (start_o !== 2'b10 || ins(1) !== 32'hB) begin
            n_fail++; $display("FAIL b2b_B_unit1: got start %b instr %h want 10/b", start_o, ins(1)); end
        step(); busy_i = 2'b11;                                     // c4
        n_cmp++; if (start_o !== 2'b00 || usage_o !== 3'd1) begin
            n_fail++; $display("FAIL b2b_C_waits: got start %b usage %0d want 00/1", start_o, usage_o); end
        step(); busy_i = 2'b10;                                     // c5
        step();                                                     // c6
        n_cmp++; if (start_o !== 2'b01 || ins(0) !== 32'hC || ins(1) !== 32'hB) begin
            n_fail++; $display("FAIL b2b_C_unit0: got start %b i0 %h i1 %h want 01/c/b", start_o, ins(0), ins(1)); end
    endtask

    task automatic test_snapshot();
        do_reset();
        busy_i = 2'b11;
        dispatch_i = 1'b1; dispatched_instr_i = 32'hBEEF; csr_config_i = 32'h11;
        step(); dispatch_i = 1'b0; csr_config_i = 32'h22;
        step();
        step(); busy_i = 2'b00;
        step();
        n_cmp++; if (start_o !== 2'b01 || ins(0) !== 32'hBEEF || cnf(0) !== 32'h11) begin
            n_fail++; $display("FAIL snapshot_conf: got start %b instr %h conf %h want 01/beef/11", start_o, ins(0), cnf(0)); end
    endtask

    task automatic test_full();
        logic [31:0] exp_q [5];
        int got;
        int u;
        do_reset();
        for (int i = 0; i < 5; i++) exp_q[i] = 32'h100 + 32'(i);
        busy_i = 2'b11;
        dispatch_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dispatched_instr_i = exp_q[i];
            if (i == 3) begin
                n_cmp++; if (dispatch_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_ready_at3: got %b want 1", dispatch_ready_o); end
            end
            step();
        end
        n_cmp++; if (dispatch_ready_o !== 1'b0 || usage_o !== 3'd4) begin
            n_fail++; $display("FAIL full_after4: got ready %b usage %0d want 0/4", dispatch_ready_o, usage_o); end
        dispatched_instr_i = exp_q[4];
        step(); dispatch_i = 1'b0;
        n_cmp++; if (usage_o !== 3'd4) begin n_fail++; $display("FAIL full_drop5: got usage %0d want 4", usage_o); end
        busy_i = 2'b00;
        got = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (start_o != 2'b00) begin
                u = start_o[1] ? 1 : 0;
                n_cmp++; if (got >= 4 || ins(u) !== exp_q[got]) begin
                    n_fail++; $display("FAIL full_order_%0d: got %h on unit %0d want %h", got, ins(u), u, exp_q[got < 4 ? got : 0]); end
                got++;
            end
        end
        n_cmp++; if (got !== 4) begin n_fail++; $display("FAIL full_issue_count: got %0d want 4", got); end
        n_cmp++; if (usage_o !== 3'd0) begin n_fail++; $display("FAIL full_drained: got usage %0d want 0", usage_o); end
    endtask

    task automatic test_flush();
        do_reset();
        dispatch_i = 1'b1; dispatched_instr_i = 32'hA;
        step(); dispatch_i = 1'b0;
        step();                                                      // c2: A issued on unit 0
        busy_i = 2'b11; dispatch_i = 1'b1; dispatched_instr_i = 32'hF0;
        step(); dispatched_instr_i = 32'hF1;
        step(); dispatched_instr_i = 32'hF2;
        step();                                                      // c5
        n_cmp++; if (usage_o !== 3'd3) begin n_fail++; $display("FAIL flush_pre_usage: got %0d want 3", usage_o); end
        flush_i = 1'b1; busy_i = 2'b00; dispatched_instr_i = 32'hDEAD;
        step(); flush_i = 1'b0; dispatch_i = 1'b0;
        n_cmp++; if (usage_o !== 3'd0 || start_o !== 2'b00) begin
            n_fail++; $display("FAIL flush_cleared: got usage %0d start %b want 0/00", usage_o, start_o); end
        step();
        n_cmp++; if (start_o !== 2'b00 || ins(0) !== 32'hA || ins(1) !== 32'h0) begin
            n_fail++; $display("FAIL flush_slices_kept: got start %b i0 %h i1 %h want 00/a/0", start_o, ins(0), ins(1)); end
        dispatch_i = 1'b1; dispatched_instr_i = 32'hE0;
        step(); dispatch_i = 1'b0;
        step();
        n_cmp++; if (start_o !== 2'b10 || ins(1) !== 32'hE0) begin
            n_fail++; $display("FAIL flush_resume_rr: got start %b i1 %h want 10/e0", start_o, ins(1)); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        busy_i = 2'b11; dispatch_i = 1'b1; dispatched_instr_i = 32'h77;
        step(); step();
        dispatch_i = 1'b0;
        rst_ni = 1'b0;
        #2;
        n_cmp++; if (usage_o !== 3'd0 || dispatch_ready_o !== 1'b1 || start_o !== 2'b00) begin
            n_fail++; $display("FAIL reset_mid: got usage %0d ready %b start %b want 0/1/00", usage_o, dispatch_ready_o, start_o); end
        step();
        rst_ni = 1'b1;
        busy_i = 2'b00;
        step(); step();
        n_cmp++; if (start_o !== 2'b00) begin n_fail++; $display("FAIL reset_mid_lost: got start %b want 00", start_o); end
    endtask

`ifdef LSU_ISSUE_STATS_EN
    task automatic test_stats();
        do_reset();
        busy_i = 2'b11; dispatch_i = 1'b1;
        dispatched_instr_i = 32'h1; step();
        dispatched_instr_i = 32'h2; step();
        dispatched_instr_i = 32'h3; step();
        dispatch_i = 1'b0;
        for (int i = 0; i < 5; i++) step();                          // now c8
        n_cmp++; if (stall_cnt_o !== 32'd7) begin n_fail++; $display("FAIL stats_stall_mid: got %0d want 7", stall_cnt_o); end
        busy_i = 2'b00;
        for (int i = 0; i < 4; i++) step();
        n_cmp++; if (issue_cnt_o !== 32'd3 || stall_cnt_o !== 32'd7) begin
            n_fail++; $display("FAIL stats_final: got issue %0d stall %0d want 3/7", issue_cnt_o, stall_cnt_o); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_snapshot();
        test_full();
        test_flush();
        test_reset_mid();
`ifdef LSU_ISSUE_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
